// File: rtl/load_store_unit_pkg.sv
// Shared core types: data/memory widths, RV32I load/store funct3 encodings, decode helpers.
package load_store_unit_pkg;

    localparam int unsigned DATA_WIDTH      = 32;
    localparam int unsigned DMEM_ADDR_WIDTH = 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Stores accept only B/H/W; loads additionally accept the unsigned variants.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!we) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

    // Access size lives in funct3[1:0]; bytes are always aligned.
    function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] off);
        logic ok;
        case (f3[1:0])
            2'b00:   ok = 1'b1;
            2'b01:   ok = ~off[0];
            2'b10:   ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Load lane extraction with sign/zero extension, and sub-word store lane merge.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]            funct3,
    input  logic [1:0]            byte_off,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [15:0]           wdata,
    output logic [DATA_WIDTH-1:0] load_data_c,
    output logic [DATA_WIDTH-1:0] merge_data_c
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Select the addressed byte and halfword lanes of the memory word.
    always_comb begin
        byte_lane = rdata[{byte_off, 3'b000} +: 8];
        half_lane = byte_off[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extend the selected lane to a full register value.
    always_comb begin
        load_data_c = '0;
        case (funct3)
            F3_B:    load_data_c = {{24{byte_lane[7]}}, byte_lane};
            F3_H:    load_data_c = {{16{half_lane[15]}}, half_lane};
            F3_W:    load_data_c = rdata;
            F3_BU:   load_data_c = {24'h0, byte_lane};
            F3_HU:   load_data_c = {16'h0, half_lane};
            default: load_data_c = '0;
        endcase
    end

    // Replace only the addressed lane of the old word for SB/SH.
    always_comb begin
        merge_data_c = rdata;
        case (funct3[1:0])
            2'b00:   merge_data_c[{byte_off, 3'b000} +: 8] = wdata[7:0];
            2'b01:   merge_data_c[{byte_off[1], 4'b0000} +: 16] = wdata;
            default: merge_data_c = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding request FSM in front of a 1-cycle read data memory.
module load_store_unit #(
    parameter int unsigned DATA_WIDTH = load_store_unit_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = load_store_unit_pkg::DMEM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    import load_store_unit_pkg::*;

    localparam int unsigned BA_WIDTH = ADDR_WIDTH + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RD_DATA,
        S_WR,
        S_ERR
    } state_t;

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [BA_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic [DATA_WIDTH-1:0] load_data_c;
    logic [DATA_WIDTH-1:0] merge_data_c;

    // Address bits above the memory size are dropped so accesses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:BA_WIDTH];

    lsu_align u_align (
        .funct3       (funct3_q),
        .byte_off     (addr_q[1:0]),
        .rdata        (mem_rdata),
        .wdata        (wdata_q[15:0]),
        .load_data_c  (load_data_c),
        .merge_data_c (merge_data_c)
    );

    // Next state and request latch; decode/alignment are resolved at acceptance.
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr[BA_WIDTH-1:0];
                    wdata_d  = req_wdata;
                    if (!f3_legal(req_we, req_funct3) || !addr_aligned(req_funct3, req_addr[1:0])) begin
                        state_d = S_ERR;
                    end else if (req_we && (req_funct3 == F3_W)) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD:      state_d = S_RD_DATA;
            S_RD_DATA: state_d = S_IDLE;
            S_WR:      state_d = S_IDLE;
            S_ERR:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // State and latched request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    // Outputs decode directly from the state register so reset clears them at once.
    always_comb begin
        req_ready  = (state_q == S_IDLE);
        resp_valid = (state_q == S_RD_DATA) || (state_q == S_WR) || (state_q == S_ERR);
        resp_err   = (state_q == S_ERR);
        resp_rdata = ((state_q == S_RD_DATA) && !we_q) ? load_data_c : '0;
        mem_addr   = addr_q[BA_WIDTH-1:2];
        mem_we     = (state_q == S_WR) || ((state_q == S_RD_DATA) && we_q);
        mem_wdata  = (state_q == S_RD_DATA) ? merge_data_c : wdata_q;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DATA_WIDTH, default `DATA_WIDTH (32), data-port width; the design SHALL support 32 only.
REQ-002 Parameter ADDR_WIDTH, default `DMEM_ADDR_WIDTH, word-address width of the data memory.
REQ-003 Ports SHALL be, as name, direction, width, meaning:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  LSU can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I size/sign encoding.
- req_addr  in  32  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_WIDTH  load result, extended; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal funct3; valid with resp_valid.
- mem_addr  out  ADDR_WIDTH  word address to memory.
- mem_we  out  1  memory write enable.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data, valid one cycle after mem_addr is sampled.

Function
REQ-004 The LSU SHALL implement FSM states IDLE, RD, RD_DATA, WR, ERR.
REQ-005 req_ready SHALL equal (state == IDLE); a request is accepted on a rising edge with req_valid && req_ready, which latches we, funct3, addr and wdata.
REQ-006 Word address SHALL be addr_q[ADDR_WIDTH+1:2]; upper bits are ignored, so addresses wrap modulo memory size.
REQ-007 Legal loads are LB 000, LH 001, LW 010, LBU 100 and LHU 101; legal stores are SB 000, SH 001 and SW 010; any other encoding SHALL be illegal.
REQ-008 Alignment rule: halfword requires addr[0]=0; word requires addr[1:0]=00; byte is always aligned.
REQ-009 Illegal or misaligned request: IDLE->ERR, and ERR SHALL drive resp_valid=1, resp_err=1, resp_rdata=0 and mem_we=0, then go to IDLE.
REQ-010 Load: IDLE->RD (mem_addr driven) ->RD_DATA. In RD_DATA, resp_valid=1 and resp_rdata is the selected lane of mem_rdata, sign- or zero-extended; then ->IDLE. Latency from acceptance edge to resp_valid is 2 cycles.
REQ-011 Byte lane SHALL be mem_rdata[8*addr[1:0] +: 8]; halfword lane SHALL be mem_rdata[16*addr[1] +: 16].
REQ-012 SW: IDLE->WR; WR drives mem_we=1, mem_wdata=wdata_q and resp_valid=1, then ->IDLE (1-cycle latency).
REQ-013 SB/SH read-modify-write: IDLE->RD->RD_DATA.
- In RD_DATA, mem_we=1 and mem_wdata = mem_rdata with the addressed lane replaced by wdata_q[7:0] or [15:0].
- mem_addr is held unchanged, and resp_valid=1 in the same cycle; then ->IDLE.
REQ-014 mem_addr SHALL be held from addr_q in every non-IDLE state; mem_we SHALL be 0 outside WR and store-RD_DATA.
REQ-015 No response backpressure: resp_valid is a single-cycle pulse, and a new request can be accepted in the cycle after resp_valid.
REQ-016 resp_rdata and resp_err SHALL be 0 whenever resp_valid=0.

Reset
REQ-017 rst_n low SHALL immediately force state=IDLE, mem_we=0, resp_valid=0 and resp_err=0, and clear all latched request registers.
REQ-018 Reset asserted mid-operation SHALL abort the access with no response; a sub-word RMW aborted in RD SHALL produce no memory write.
REQ-019 req_ready SHALL be 1 during and after reset.

Structure
REQ-020 funct3 encoding constants SHALL reside in the shared core types package alongside DATA_WIDTH and DMEM_ADDR_WIDTH; the FSM state enum is local.
REQ-021 Lane extraction/extension and store-lane merge SHALL be a combinational sub-module lsu_align; the FSM remains in load_store_unit.

Verification
REQ-022 The bench SHALL model memory as a 1-cycle registered-read array and SHALL cover:
- Preload word 0x8001F0A5 at byte address 0x10; LB 0x10 -> 0xFFFFFFA5; LBU 0x11 -> 0x000000F0; LH 0x12 -> 0xFFFF8001; LHU 0x12 -> 0x00008001; each resp_valid exactly 2 cycles after acceptance.
- SW 0xDEADBEEF to 0x20, then LW 0x20 -> 0xDEADBEEF; the store response comes 1 cycle after acceptance.
- Preload 0x11223344 at 0x30; SB 0xAA to 0x31 -> memory 0x1122AA44; then SH 0x5566 to 0x32 -> 0x55662A44 is wrong, memory SHALL read 0x5566AA44; exactly one mem_we pulse per store.
- LW 0x21, SH 0x33 and funct3=011 load -> resp_err=1, resp_rdata=0, no mem_we, and memory unchanged.
- Back-to-back requests with req_valid held high: req_ready low in non-IDLE states, no request dropped or duplicated.
- rst_n pulsed low during RD of an SB -> no write occurs, no resp_valid, and req_ready=1 while rst_n is low.
